// File: rtl/fifo_readout_seq.sv
// Event readout sequencer: pops an event descriptor, emits header words, drains each
// selected channel FIFO up to its last-flagged word (with timeout), then a trailer.
// Optional build macro READOUT_CHKSUM_EN appends an XOR checksum word after the trailer.
module fifo_readout_seq #(
    parameter int unsigned NCH  = 7,
    parameter int unsigned DW   = 16,
    parameter logic [8:0]  STMO = 9'd40
) (
    input  logic           CLKCMS,
    input  logic           RST,
    input  logic           L1ARST,
    input  logic           DAV_VLD,
    input  logic [NCH-1:0] DAV_MASK,
    output logic           DAV_POP,
    input  logic [NCH-1:0] KILL,
    input  logic [11:0]    DAQMBID,
    input  logic [NCH-1:0] FIFO_RDY,
    output logic [NCH-1:0] OEFIFO_B,
    output logic [NCH-1:0] RENFIFO_B,
    input  logic [DW:0]    DATAIN,
    output logic [DW-1:0]  DOUT,
    output logic           DOUT_VLD,
    output logic           DOUT_LAST,
    output logic [NCH-1:0] TMO_FLAGS
);
    localparam int unsigned CW = $clog2(NCH);

    typedef enum logic [3:0] {
        S_IDLE, S_POP, S_HDR1, S_HDR2, S_SEL, S_WAIT, S_READ, S_TRL, S_CHK
    } state_t;

    state_t         state;
    logic [NCH-1:0] pending;
    logic [CW-1:0]  ch;
    logic [8:0]     timer;
    logic [23:0]    l1acnt;
    logic           rd_d1;
`ifdef READOUT_CHKSUM_EN
    logic [DW-1:0]  csum;
`endif

    logic           sel_any;
    logic [CW-1:0]  sel_idx;
    logic           emit;
    logic [DW-1:0]  word;
    logic           last_word;
    logic           ren_go;

    // A last-flagged word on DATAIN blocks any further read from that channel in the same cycle.
    assign last_word = rd_d1 && DATAIN[DW];
    assign ren_go    = (state == S_READ) && FIFO_RDY[ch] && !last_word;
    assign RENFIFO_B = OEFIFO_B | ~{NCH{ren_go}};

    // Lowest pending channel and the word to emit this cycle.
    always_comb begin
        sel_any = |pending;
        sel_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) sel_idx = CW'(i);
        end
        emit = 1'b0;
        word = '0;
        case (state)
            S_HDR1: begin emit = 1'b1; word = DW'({4'h9, l1acnt[11:0]}); end
            S_HDR2: begin emit = 1'b1; word = DW'({4'hA, DAQMBID}); end
            S_TRL:  begin emit = 1'b1; word = DW'({4'hF, 12'(TMO_FLAGS)}); end
`ifdef READOUT_CHKSUM_EN
            S_CHK:  begin emit = 1'b1; word = csum; end
`endif
            default: begin
                if (rd_d1) begin
                    emit = 1'b1;
                    word = DATAIN[DW-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            pending   <= '0;
            ch        <= '0;
            timer     <= '0;
            l1acnt    <= '0;
            rd_d1     <= 1'b0;
            DAV_POP   <= 1'b0;
            OEFIFO_B  <= '1;
            DOUT      <= '0;
            DOUT_VLD  <= 1'b0;
            DOUT_LAST <= 1'b0;
            TMO_FLAGS <= '0;
`ifdef READOUT_CHKSUM_EN
            csum      <= '0;
`endif
        end else begin
            DAV_POP   <= 1'b0;
            DOUT_VLD  <= emit;
            DOUT_LAST <= 1'b0;
            rd_d1     <= ren_go;
            if (emit) begin
                DOUT <= word;
`ifdef READOUT_CHKSUM_EN
                csum <= csum ^ word;
`endif
            end
            // Clear wins over a coincident trailer increment.
            if (L1ARST)              l1acnt <= '0;
            else if (state == S_TRL) l1acnt <= l1acnt + 24'd1;

            case (state)
                S_IDLE: begin
                    if (DAV_VLD) begin
                        DAV_POP <= 1'b1;
                        state   <= S_POP;
                    end
                end
                S_POP: begin
                    pending   <= DAV_MASK & ~KILL;
                    TMO_FLAGS <= '0;
`ifdef READOUT_CHKSUM_EN
                    csum      <= '0;
`endif
                    state     <= S_HDR1;
                end
                S_HDR1: state <= S_HDR2;
                S_HDR2: state <= S_SEL;
                S_SEL: begin
                    if (sel_any) begin
                        ch       <= sel_idx;
                        OEFIFO_B <= ~(NCH'(1) << sel_idx);
                        timer    <= '0;
                        state    <= S_WAIT;
                    end else begin
                        state    <= S_TRL;
                    end
                end
                S_WAIT: begin
                    if (FIFO_RDY[ch]) begin
                        timer <= '0;
                        state <= S_READ;
                    end else if (timer == STMO) begin
                        TMO_FLAGS[ch] <= 1'b1;
                        pending[ch]   <= 1'b0;
                        OEFIFO_B      <= '1;
                        state         <= S_SEL;
                    end else begin
                        timer <= timer + 9'd1;
                    end
                end
                S_READ: begin
                    if (last_word) begin
                        pending[ch] <= 1'b0;
                        OEFIFO_B    <= '1;
                        state       <= S_SEL;
                    end else if (!FIFO_RDY[ch]) begin
                        timer <= '0;
                        state <= S_WAIT;
                    end
                end
                S_TRL: begin
`ifdef READOUT_CHKSUM_EN
                    state     <= S_CHK;
`else
                    DOUT_LAST <= 1'b1;
                    state     <= S_IDLE;
`endif
                end
                S_CHK: begin
                    DOUT_LAST <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_readout_seq.sv
// Bench for fifo_readout_seq: behavioural channel FIFOs and an event-frame reference model.
module tb_fifo_readout_seq;
    localparam int unsigned NCH   = 7;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;

    logic           CLKCMS = 1'b0;
    logic           RST = 1'b1;
    logic           L1ARST = 1'b0;
    logic           DAV_VLD = 1'b0;
    logic [NCH-1:0] DAV_MASK = '0;
    logic           DAV_POP;
    logic [NCH-1:0] KILL = '0;
    logic [11:0]    DAQMBID = '0;
    logic [NCH-1:0] FIFO_RDY;
    logic [NCH-1:0] OEFIFO_B;
    logic [NCH-1:0] RENFIFO_B;
    logic [DW:0]    DATAIN = '0;
    logic [DW-1:0]  DOUT;
    logic           DOUT_VLD;
    logic           DOUT_LAST;
    logic [NCH-1:0] TMO_FLAGS;

    fifo_readout_seq #(.NCH(NCH), .DW(DW), .STMO(9'd40)) dut (
        .CLKCMS(CLKCMS), .RST(RST), .L1ARST(L1ARST), .DAV_VLD(DAV_VLD),
        .DAV_MASK(DAV_MASK), .DAV_POP(DAV_POP), .KILL(KILL), .DAQMBID(DAQMBID),
        .FIFO_RDY(FIFO_RDY), .OEFIFO_B(OEFIFO_B), .RENFIFO_B(RENFIFO_B),
        .DATAIN(DATAIN), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_LAST(DOUT_LAST),
        .TMO_FLAGS(TMO_FLAGS)
    );

    always #5 CLKCMS = ~CLKCMS;

    // Channel FIFOs: loaded by the stimulus, popped by RENFIFO_B, word presented next cycle.
    logic [DW:0]    mem [NCH][DEPTH];
    int unsigned    wp [NCH] = '{default: 0};
    int unsigned    rp [NCH] = '{default: 0};
    logic [NCH-1:0] stall = '0;
    logic           flush = 1'b0;
    int             underflow = 0;

    always_comb begin
        for (int c = 0; c < NCH; c++) FIFO_RDY[c] = (rp[c] != wp[c]) && !stall[c];
    end

    always @(posedge CLKCMS) begin
        for (int c = 0; c < NCH; c++) begin
            if (flush) rp[c] <= wp[c];
            else if (!RENFIFO_B[c]) begin
                if (rp[c] == wp[c]) underflow <= underflow + 1;
                else begin
                    DATAIN <= mem[c][rp[c] % DEPTH];
                    rp[c]  <= rp[c] + 1;
                end
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    logic [DW:0] got [$];
    int pops = 0, viol = 0, ren_idle = 0, ren_any = 0;
    int oe_low [NCH] = '{default: 0};

    always @(negedge CLKCMS) begin
        if (!RST) begin
            if (DOUT_VLD) got.push_back({DOUT_LAST, DOUT});
            if (DAV_POP) pops++;
            if ((((~RENFIFO_B) & OEFIFO_B) != '0) || ($countones(~OEFIFO_B) > 1) ||
                ($countones(~RENFIFO_B) > 1)) viol++;
            if (((~RENFIFO_B) & ~FIFO_RDY) != '0) ren_idle++;
            if (RENFIFO_B != '1) ren_any++;
            for (int c = 0; c < NCH; c++) if (!OEFIFO_B[c]) oe_low[c]++;
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: event counter, per-event channel contents, expected frame.
    logic [23:0]    l1a = '0;
    int             nw [NCH];
    logic [DW:0]    chq [NCH][$];
    logic [DW:0]    exp_q [$];
    logic [NCH-1:0] exp_flags;

    task automatic load_fifos(input logic [NCH-1:0] ch_set);
        logic [DW-1:0] w;
        logic          lst;
        for (int c = 0; c < NCH; c++) begin
            chq[c].delete();
            if (ch_set[c]) begin
                for (int k = 0; k < nw[c]; k++) begin
                    w   = DW'($urandom);
                    lst = (k == nw[c] - 1);
                    mem[c][wp[c] % DEPTH] = {lst, w};
                    wp[c] = wp[c] + 1;
                    chq[c].push_back({lst, w});
                end
            end
        end
    endtask

    // Frame = HDR1, HDR2, data of each live channel in ascending order, trailer.
    task automatic build_expected(input logic [NCH-1:0] mask, input logic [NCH-1:0] kill);
        logic [DW-1:0] x;
        exp_q.delete();
        exp_flags = '0;
        exp_q.push_back({1'b0, 4'h9, l1a[11:0]});
        exp_q.push_back({1'b0, 4'hA, DAQMBID});
        for (int c = 0; c < NCH; c++) begin
            if (mask[c] && !kill[c]) begin
                if (chq[c].size() == 0) exp_flags[c] = 1'b1;
                else foreach (chq[c][k]) exp_q.push_back({1'b0, chq[c][k][DW-1:0]});
            end
        end
`ifdef READOUT_CHKSUM_EN
        exp_q.push_back({1'b0, 4'hF, 12'(exp_flags)});
        x = '0;
        foreach (exp_q[k]) x = x ^ exp_q[k][DW-1:0];
        exp_q.push_back({1'b1, x});
`else
        x = '0;
        exp_q.push_back({1'b1, 4'hF, 12'(exp_flags)});
`endif
    endtask

    task automatic run_event(input string tag, input logic [NCH-1:0] mask,
                             input logic [NCH-1:0] kill, input int stall_ch, input int stall_at);
        int b_got, b_pop, b_viol, b_idle, b_uf, cyc, n;
        bit done;
        load_fifos(mask);
        build_expected(mask, kill);
        b_got = got.size(); b_pop = pops; b_viol = viol; b_idle = ren_idle; b_uf = underflow;
        DAV_MASK = mask; KILL = kill; DAV_VLD = 1'b1;
        cyc = 0; done = 0;
        while (!done && cyc < 2000) begin
            @(posedge CLKCMS); #1; cyc++;
            if (DAV_POP) DAV_VLD = 1'b0;
            if (stall_ch >= 0) stall[stall_ch] = (cyc >= stall_at) && (cyc < stall_at + 5);
            if (got.size() > b_got && got[got.size()-1][DW]) done = 1;
        end
        stall = '0;
        DAV_VLD = 1'b0;
        check({tag, ".done"}, 32'(done), 32'd1);
        n = got.size() - b_got;
        check({tag, ".nwords"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("%s.w%0d", tag, i), 32'(got[b_got + i]), 32'(exp_q[i]));
        check({tag, ".pops"}, 32'(pops - b_pop), 32'd1);
        check({tag, ".onehot"}, 32'(viol - b_viol), 32'd0);
        check({tag, ".ren_norrdy"}, 32'(ren_idle - b_idle), 32'd0);
        check({tag, ".underflow"}, 32'(underflow - b_uf), 32'd0);
        check({tag, ".tmo"}, 32'(TMO_FLAGS), 32'(exp_flags));
        l1a = L1ARST ? 24'd0 : l1a + 24'd1;
        flush = 1'b1;
        @(posedge CLKCMS); #1;
        flush = 1'b0;
    endtask

    initial begin
        int b_oe, b_ren, cyc;
        logic [NCH-1:0] m, k;

        repeat (3) @(posedge CLKCMS);
        #1;
        check("rst.pop", 32'(DAV_POP), 32'd0);
        check("rst.oe", 32'(OEFIFO_B), 32'h7F);
        check("rst.ren", 32'(RENFIFO_B), 32'h7F);
        check("rst.dout", 32'(DOUT), 32'd0);
        check("rst.vld", 32'({DOUT_VLD, DOUT_LAST}), 32'd0);
        check("rst.tmo", 32'(TMO_FLAGS), 32'd0);
        RST = 1'b0;
        @(posedge CLKCMS); #1;

        // Two channels, three words each.
        DAQMBID = 12'h5A3;
        nw = '{default: 0}; nw[3] = 3; nw[4] = 3;
        run_event("two_ch", 7'h18, 7'h00, -1, 0);

        // One channel never ready: times out after 41 enable cycles.
        nw = '{default: 0}; nw[6] = 3;
        b_oe = oe_low[5];
        run_event("timeout", 7'h60, 7'h00, -1, 0);
        check("timeout.oe_cycles", 32'(oe_low[5] - b_oe), 32'd41);

        // Killed channel: header/trailer only and no read enable at all.
        nw = '{default: 0}; nw[3] = 3;
        b_ren = ren_any;
        run_event("killed", 7'h08, 7'h08, -1, 0);
        check("killed.no_ren", 32'(ren_any - b_ren), 32'd0);

        // Ready drops for 5 cycles in the middle of a channel.
        nw = '{default: 0}; nw[3] = 8;
        run_event("stall", 7'h08, 7'h00, 3, 8);

        // Counter clear held across a trailer, then the next header still reads 0.
        L1ARST = 1'b1;
        @(posedge CLKCMS); #1;
        l1a = '0;
        nw = '{default: 0}; nw[0] = 2;
        run_event("l1arst", 7'h01, 7'h00, -1, 0);
        L1ARST = 1'b0;
        nw = '{default: 0};
        run_event("after_clr", 7'h00, 7'h00, -1, 0);

        // Reset in the middle of a read burst.
        nw = '{default: 0}; nw[0] = 8;
        load_fifos(7'h01);
        DAV_MASK = 7'h01; KILL = '0; DAV_VLD = 1'b1;
        cyc = 0;
        while (RENFIFO_B == '1 && cyc < 100) begin
            @(posedge CLKCMS); #1; cyc++;
            if (DAV_POP) DAV_VLD = 1'b0;
        end
        DAV_VLD = 1'b0;
        check("midrst.reached_read", 32'(RENFIFO_B != '1), 32'd1);
        RST = 1'b1;
        #1;
        check("midrst.oe", 32'(OEFIFO_B), 32'h7F);
        check("midrst.ren", 32'(RENFIFO_B), 32'h7F);
        check("midrst.dout", 32'({DAV_POP, DOUT_VLD, DOUT_LAST, DOUT}), 32'd0);
        check("midrst.tmo", 32'(TMO_FLAGS), 32'd0);
        @(posedge CLKCMS); #1;
        RST = 1'b0;
        l1a = '0;
        flush = 1'b1;
        @(posedge CLKCMS); #1;
        flush = 1'b0;
        nw = '{default: 0};
        run_event("post_rst", 7'h00, 7'h00, -1, 0);

        // Randomized events.
        for (int e = 0; e < 16; e++) begin
            DAQMBID = 12'($urandom);
            m = NCH'($urandom);
            k = NCH'($urandom & $urandom);
            for (int c = 0; c < NCH; c++)
                nw[c] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4));
            if ($urandom_range(0, 4) == 0) begin
                L1ARST = 1'b1;
                @(posedge CLKCMS); #1;
                L1ARST = 1'b0;
                l1a = '0;
            end
            run_event($sformatf("rnd%0d", e), m, k,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NCH - 1)) : -1,
                      int'($urandom_range(5, 20)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
